// File: rtl/echo_pkg.sv
// Shared types and constants for the echo queue: entry type tag, entry layout
// and the delay counter width.
package echo_pkg;

   localparam int ENTRY_DATA_W = 32;
   localparam int DLY_W        = 8;

   typedef enum logic {
      SAY  = 1'b0,
      SAY2 = 1'b1
   } entry_type_e;

   // Queue entry as stored in the FIFO; a SAY2 payload is {a, b}.
   typedef struct packed {
      entry_type_e               kind;
      logic [ENTRY_DATA_W-1:0]   payload;
   } entry_t;

endpackage

// File: rtl/echo_fifo.sv
// In-order FIFO with two write ports per cycle; push0 lands before push1.
// Head data is read combinationally from the read pointer.
module echo_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 33
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       push0_i,
   input  logic [W-1:0]               push0_data_i,
   input  logic                       push1_i,
   input  logic [W-1:0]               push1_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q, wr1;
   logic [CW-1:0] count_q;

   // push1 goes into the slot after push0 when both are written together
   assign wr1 = push0_i ? wr_q + AW'(1) : wr_q;

   // NOTE: storage is deliberately left out of reset; occupancy alone decides validity.
   always_ff @(posedge CLK) begin
      if (push0_i) mem_q[wr_q] <= push0_data_i;
      if (push1_i) mem_q[wr1]  <= push1_data_i;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_q + AW'(push0_i) + AW'(push1_i);
         rd_q    <= rd_q + AW'(pop_i);
         count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/echo_queue.sv
// Echo server: queues say/say2 requests, holds each new head for DELAY cycles,
// then echoes it on heard/heard2. Also keeps an LED register and zsay4 counter.
module echo_queue
   import echo_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int DELAY  = 1,
   parameter int LED_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      request_say_ena,
   input  logic [DATA_W-1:0]         request_say_v,
   output logic                      request_say_rdy,
   input  logic                      request_say2_ena,
   input  logic [DATA_W/2-1:0]       request_say2_a,
   input  logic [DATA_W/2-1:0]       request_say2_b,
   output logic                      request_say2_rdy,
   input  logic                      request_set_leds_ena,
   input  logic [LED_W-1:0]          request_set_leds_v,
   output logic                      request_set_leds_rdy,
   input  logic                      request_zsay4_ena,
   output logic                      request_zsay4_rdy,
   output logic                      indication_heard_ena,
   output logic [DATA_W-1:0]         indication_heard_v,
   input  logic                      indication_heard_rdy,
   output logic                      indication_heard2_ena,
   output logic [DATA_W/2-1:0]       indication_heard2_a,
   output logic [DATA_W/2-1:0]       indication_heard2_b,
   input  logic                      indication_heard2_rdy,
   output logic [LED_W-1:0]          leds,
   output logic [CNT_W-1:0]          zsay4_count,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int HW = DATA_W / 2;
   localparam int EW = DATA_W + 1;

   logic [CW-1:0]    count;
   logic [EW-1:0]    head, say_entry, say2_entry;
   logic             say_push, say2_push, pop, head_valid, eligible, head_load;
   entry_type_e      head_kind;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [LED_W-1:0] leds_q;
   logic [CNT_W-1:0] cnt_q;

   assign say_entry  = {SAY, request_say_v};
   assign say2_entry = {SAY2, request_say2_a, request_say2_b};

   // RDY looks only at registered occupancy, never at a same-cycle dequeue
   assign request_say_rdy      = count < CW'(DEPTH);
   assign request_say2_rdy     = count <= CW'(DEPTH - 2);
   assign request_set_leds_rdy = 1'b1;
   assign request_zsay4_rdy    = 1'b1;

   assign say_push  = request_say_ena & request_say_rdy;
   assign say2_push = request_say2_ena & request_say2_rdy;

   echo_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .CLK          (CLK),
      .nRST         (nRST),
      .push0_i      (say_push),
      .push0_data_i (say_entry),
      .push1_i      (say2_push),
      .push1_data_i (say2_entry),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count)
   );

   assign head_valid = count != '0;
   assign head_kind  = entry_type_e'(head[DATA_W]);
   assign eligible   = dly_q == '0;

   // Gating with nRST keeps a stale head from firing during the reset cycle
   assign indication_heard_ena  = nRST & head_valid & eligible & (head_kind == SAY)
                                  & indication_heard_rdy;
   assign indication_heard2_ena = nRST & head_valid & eligible & (head_kind == SAY2)
                                  & indication_heard2_rdy;
   assign pop = indication_heard_ena | indication_heard2_ena;

   assign indication_heard_v  = head_valid ? head[DATA_W-1:0] : '0;
   assign indication_heard2_a = head_valid ? head[DATA_W-1 -: HW] : '0;
   assign indication_heard2_b = head_valid ? head[HW-1:0] : '0;

   // A new head appears on enqueue into empty, or on a pop that leaves entries behind
   assign head_load = (!head_valid & (say_push | say2_push))
                    | (pop & ((count > CW'(1)) | say_push | say2_push));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      dly_d = dly_q;
      if (head_load)
         dly_d = DLY_W'(DELAY);
      else if (!eligible && head_valid)
         dly_d = dly_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         dly_q  <= '0;
         leds_q <= '0;
         cnt_q  <= '0;
      end else begin
         dly_q <= dly_d;
         if (request_set_leds_ena) leds_q <= request_set_leds_v;
         if (request_zsay4_ena)    cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign leds        = leds_q;
   assign zsay4_count = cnt_q;
   assign occupancy   = count;

endmodule

// File: tb/tb_echo_queue.sv
// Directed bench for echo_queue (DEPTH=4, DATA_W=32, DELAY=1) with
// hand-computed expectations.
module tb_echo_queue;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        say_ena, say_rdy, say2_ena, say2_rdy;
   logic [31:0] say_v;
   logic [15:0] say2_a, say2_b;
   logic        leds_ena, leds_rdy, z_ena, z_rdy;
   logic [7:0]  leds_v, leds;
   logic        heard_ena, heard_rdy, heard2_ena, heard2_rdy;
   logic [31:0] heard_v;
   logic [15:0] heard2_a, heard2_b;
   logic [15:0] zcount;
   logic [2:0]  occ;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   echo_queue #(.DEPTH(4), .DATA_W(32), .DELAY(1), .LED_W(8), .CNT_W(16)) dut (
      .CLK                   (CLK),
      .nRST                  (nRST),
      .request_say_ena       (say_ena),
      .request_say_v         (say_v),
      .request_say_rdy       (say_rdy),
      .request_say2_ena      (say2_ena),
      .request_say2_a        (say2_a),
      .request_say2_b        (say2_b),
      .request_say2_rdy      (say2_rdy),
      .request_set_leds_ena  (leds_ena),
      .request_set_leds_v    (leds_v),
      .request_set_leds_rdy  (leds_rdy),
      .request_zsay4_ena     (z_ena),
      .request_zsay4_rdy     (z_rdy),
      .indication_heard_ena  (heard_ena),
      .indication_heard_v    (heard_v),
      .indication_heard_rdy  (heard_rdy),
      .indication_heard2_ena (heard2_ena),
      .indication_heard2_a   (heard2_a),
      .indication_heard2_b   (heard2_b),
      .indication_heard2_rdy (heard2_rdy),
      .leds                  (leds),
      .zsay4_count           (zcount),
      .occupancy             (occ)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change just after the falling edge; the next rising edge samples them.
   task automatic next_cycle();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0; say_ena = 0; say_v = '0; say2_ena = 0; say2_a = '0; say2_b = '0;
      leds_ena = 0; leds_v = '0; z_ena = 0; heard_rdy = 0; heard2_rdy = 0;
      next_cycle(); next_cycle();
      nRST = 1'b1;
      next_cycle();

      // Idle after reset
      check("rst_occ", 32'(occ), 0);
      check("rst_say_rdy", 32'(say_rdy), 1);
      check("rst_say2_rdy", 32'(say2_rdy), 1);
      check("rst_heard_ena", 32'(heard_ena), 0);
      check("rst_heard2_ena", 32'(heard2_ena), 0);
      check("rst_leds", 32'(leds), 0);
      check("rst_zcount", 32'(zcount), 0);
      check("leds_rdy", 32'(leds_rdy), 1);
      check("zsay4_rdy", 32'(z_rdy), 1);

      // Single say, DELAY=1: indicated two cycles after the request cycle
      heard_rdy = 1; heard2_rdy = 1;
      say_ena = 1; say_v = 32'h1234_5678;
      next_cycle();
      say_ena = 0; #1;
      check("s1_occ_t1", 32'(occ), 1);
      check("s1_ena_t1", 32'(heard_ena), 0);
      next_cycle();
      check("s1_ena_t2", 32'(heard_ena), 1);
      check("s1_v_t2", heard_v, 32'h1234_5678);
      next_cycle();
      check("s1_occ_t3", 32'(occ), 0);
      check("s1_ena_t3", 32'(heard_ena), 0);

      // say and say2 together: say first, say2 DELAY+1 cycles later
      say_ena = 1; say_v = 32'hA; say2_ena = 1; say2_a = 16'h1; say2_b = 16'h2;
      next_cycle();
      say_ena = 0; say2_ena = 0; #1;
      check("dual_occ", 32'(occ), 2);
      check("dual_ena_t1", 32'(heard_ena), 0);
      next_cycle();
      check("dual_heard", 32'(heard_ena), 1);
      check("dual_heard_v", heard_v, 32'hA);
      check("dual_heard2_quiet", 32'(heard2_ena), 0);
      next_cycle();
      check("dual_occ_t3", 32'(occ), 1);
      check("dual_gap", 32'(heard2_ena), 0);
      next_cycle();
      check("dual_heard2", 32'(heard2_ena), 1);
      check("dual_heard2_a", 32'(heard2_a), 32'h1);
      check("dual_heard2_b", 32'(heard2_b), 32'h2);
      check("dual_heard_quiet", 32'(heard_ena), 0);
      next_cycle();
      check("dual_occ_end", 32'(occ), 0);

      // Fill to DEPTH with the sink blocked, then drain in order
      heard_rdy = 0; #1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("fill%0d_say_rdy", k), 32'(say_rdy), 1);
         check($sformatf("fill%0d_say2_rdy", k), 32'(say2_rdy), (k <= 3) ? 1 : 0);
         say_ena = 1; say_v = 32'(k * 16 + k);
         next_cycle();
      end
      say_ena = 0; #1;
      check("full_occ", 32'(occ), 4);
      check("full_say_rdy", 32'(say_rdy), 0);
      check("full_say2_rdy", 32'(say2_rdy), 0);
      check("full_blocked", 32'(heard_ena), 0);
      heard_rdy = 1; #1;
      check("drain1_ena", 32'(heard_ena), 1);
      check("drain1_v", heard_v, 32'h11);
      for (int k = 2; k <= 4; k++) begin
         next_cycle();
         check($sformatf("drain%0d_gap", k), 32'(heard_ena), 0);
         next_cycle();
         check($sformatf("drain%0d_ena", k), 32'(heard_ena), 1);
         check($sformatf("drain%0d_v", k), heard_v, 32'(k * 16 + k));
      end
      next_cycle();
      check("drain_occ_end", 32'(occ), 0);

      // say2 at head with heard2 blocked stalls the say behind it
      heard2_rdy = 0;
      say2_ena = 1; say2_a = 16'h3; say2_b = 16'h4;
      next_cycle();
      say2_ena = 0; say_ena = 1; say_v = 32'h55;
      next_cycle();
      say_ena = 0; #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("stall%0d_heard", k), 32'(heard_ena), 0);
         check($sformatf("stall%0d_heard2", k), 32'(heard2_ena), 0);
         next_cycle();
      end
      check("stall_occ", 32'(occ), 2);
      heard2_rdy = 1; #1;
      check("unstall_heard2", 32'(heard2_ena), 1);
      check("unstall_a", 32'(heard2_a), 32'h3);
      check("unstall_b", 32'(heard2_b), 32'h4);
      next_cycle();
      check("unstall_gap", 32'(heard_ena), 0);
      next_cycle();
      check("unstall_heard", 32'(heard_ena), 1);
      check("unstall_v", heard_v, 32'h55);
      next_cycle();

      // LEDs and zsay4 counter
      leds_ena = 1; leds_v = 8'h5A;
      next_cycle();
      leds_ena = 0; #1;
      check("leds", 32'(leds), 32'h5A);
      for (int k = 0; k < 3; k++) begin
         z_ena = 1;
         next_cycle();
      end
      z_ena = 0; #1;
      check("zcount", 32'(zcount), 3);

      // Reset mid-drain: head would be eligible, but nothing may fire
      heard_rdy = 0;
      say_ena = 1; say_v = 32'h77;
      next_cycle();
      say_v = 32'h88;
      next_cycle();
      say_ena = 0;
      next_cycle();
      check("pre_rst_occ", 32'(occ), 2);
      heard_rdy = 1; nRST = 0; #1;
      check("rst_cycle_heard", 32'(heard_ena), 0);
      next_cycle();
      nRST = 1; #1;
      check("post_rst_occ", 32'(occ), 0);
      check("post_rst_heard", 32'(heard_ena), 0);
      check("post_rst_leds", 32'(leds), 0);
      check("post_rst_zcount", 32'(zcount), 0);

      // Fresh traffic after reset still echoes correctly
      say_ena = 1; say_v = 32'hCAFE_F00D;
      next_cycle();
      say_ena = 0;
      next_cycle();
      check("post_rst_echo", 32'(heard_ena), 1);
      check("post_rst_echo_v", heard_v, 32'hCAFE_F00D);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
